hex_display_arbiter: RTL and testbench

Shares the board's six 7-segment displays (HEX0..HEX5) between two independent requesters, using a registered round-robin grant with a minimum hold time.
The granted requester's 24-bit value is decoded into six active-low digits, one nibble per display, with a per-digit blank mask.
It sits between the application logic and the board HEX outputs, so the emulator captures all six display buses from one owner.

---
 rtl/hex_display_arbiter.sv | 172 +++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the six HEX displays for two requesters, with a minimum grant hold.
// Latency: GNT one edge after REQ is sampled; HEX one edge after GNT.
// Backpressure: none; a requester simply waits while the other holds the grant.
module hex_display_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  REQ,
    input  logic [23:0] DATA0,
    input  logic [23:0] DATA1,
    input  logic [5:0]  BLANK0,
    input  logic [5:0]  BLANK1,
    output logic [1:0]  GNT,
    output logic        BUSY,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_served_q;
    logic               expired;
    logic [1:0]         gnt_q;
    logic [1:0]         gnt_d;
    logic               busy_q;
    logic [5:0][6:0]    hex_q;
    logic [5:0][6:0]    hex_d;
    logic               own_vld;
    logic [23:0]        own_dat;
    logic [5:0]         own_blank;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign expired = (cnt_q == CNT_MAX);

    // State, hold counter, round-robin pointer and all output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_served_q <= 1'b1;
            gnt_q         <= 2'b00;
            busy_q        <= 1'b0;
            hex_q         <= {6{SEG_OFF}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= |gnt_d;
            hex_q   <= hex_d;
            if (state_d != state_q && state_d != IDLE) begin
                cnt_q         <= '0;
                last_served_q <= (state_d == OWN1);
            end else if (state_d == IDLE) begin
                cnt_q <= '0;
            end else if (!expired) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (REQ)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = last_served_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0: begin
                // Switching straight to the other side takes priority over going idle.
                if (expired && REQ[1]) begin
                    state_d = OWN1;
                end else if (expired && !REQ[0]) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (expired && REQ[0]) begin
                    state_d = OWN0;
                end else if (expired && !REQ[1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = 2'b00;
        own_vld   = 1'b0;
        own_dat   = DATA0;
        own_blank = BLANK0;
        hex_d     = {6{SEG_OFF}};
        case (state_d)
            OWN0:    gnt_d = 2'b01;
            OWN1:    gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase
        // HEX follows the owner before this edge, so it trails GNT by one cycle.
        case (state_q)
            OWN0: begin
                own_vld   = 1'b1;
                own_dat   = DATA0;
                own_blank = BLANK0;
            end
            OWN1: begin
                own_vld   = 1'b1;
                own_dat   = DATA1;
                own_blank = BLANK1;
            end
            default: own_vld = 1'b0;
        endcase
        for (int k = 0; k < 6; k++) begin
            if (own_vld && !own_blank[k]) begin
                hex_d[k] = seg7(own_dat[4*k +: 4]);
            end
        end
    end

    assign GNT  = gnt_q;
    assign BUSY = busy_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

    gnt_onehot: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(GNT));
    busy_match: assert property (@(posedge CLK) disable iff (!RST_N) BUSY == (GNT != 2'b00));

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances share stimulus;
// a per-cycle reference model fills expectation queues that a separate monitor drains.
module tb_hex_display_arbiter;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        busy;
        logic [41:0] hex;
    } obs_t;

    localparam logic [6:0] SEG_TBL [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam obs_t RST_OBS = '{gnt: 2'b00, busy: 1'b0, hex: {6{7'h7F}}};

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  REQ;
    logic [23:0] DATA0, DATA1;
    logic [5:0]  BLANK0, BLANK1;

    logic [1:0]  a_gnt, b_gnt;
    logic        a_busy, b_busy;
    logic [6:0]  a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
    logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
    obs_t        obs_a, obs_b;

    int compared   = 0;
    int mismatched = 0;

    int own [2] = '{-1, -1};
    int age [2] = '{0, 0};
    int ls  [2] = '{1, 1};
    int hold [2] = '{4, 1};
    obs_t q0[$];
    obs_t q1[$];

    always #5 CLK = ~CLK;

    hex_display_arbiter #(.HOLD_CYCLES(4)) dut_h4 (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
        .DATA0(DATA0), .DATA1(DATA1), .BLANK0(BLANK0), .BLANK1(BLANK1),
        .GNT(a_gnt), .BUSY(a_busy),
        .HEX0(a_hex0), .HEX1(a_hex1), .HEX2(a_hex2),
        .HEX3(a_hex3), .HEX4(a_hex4), .HEX5(a_hex5)
    );

    hex_display_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
        .DATA0(DATA0), .DATA1(DATA1), .BLANK0(BLANK0), .BLANK1(BLANK1),
        .GNT(b_gnt), .BUSY(b_busy),
        .HEX0(b_hex0), .HEX1(b_hex1), .HEX2(b_hex2),
        .HEX3(b_hex3), .HEX4(b_hex4), .HEX5(b_hex5)
    );

    assign obs_a = {a_gnt, a_busy, a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0};
    assign obs_b = {b_gnt, b_busy, b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t got gnt=%b busy=%b hex=%h, expected gnt=%b busy=%b hex=%h",
                     name, $time, act.gnt, act.busy, act.hex, exp.gnt, exp.busy, exp.hex);
        end
    endtask

    // Owner is -1 when idle; age counts cycles since the grant began.
    function automatic obs_t model_step(input int m);
        obs_t        e;
        int          o, n;
        logic [23:0] d;
        logic [5:0]  b;
        o     = own[m];
        e.hex = {6{7'h7F}};
        if (o >= 0) begin
            d = (o == 1) ? DATA1 : DATA0;
            b = (o == 1) ? BLANK1 : BLANK0;
            for (int k = 0; k < 6; k++)
                if (!b[k]) e.hex[7*k +: 7] = SEG_TBL[d[4*k +: 4]];
        end
        n = o;
        if (o < 0) begin
            if (REQ == 2'b11)      n = 1 - ls[m];
            else if (REQ == 2'b01) n = 0;
            else if (REQ == 2'b10) n = 1;
        end else if (age[m] >= hold[m] - 1) begin
            if (REQ[1-o])          n = 1 - o;
            else if (REQ == 2'b00) n = -1;
        end
        if (n != o) begin
            age[m] = 0;
            if (n >= 0) ls[m] = n;
        end else if (n >= 0) begin
            age[m] = age[m] + 1;
        end
        own[m] = n;
        e.gnt  = (n == 0) ? 2'b01 : (n == 1) ? 2'b10 : 2'b00;
        e.busy = (n >= 0);
        return e;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m] = -1;
            age[m] = 0;
            ls[m]  = 1;
        end
        q0.delete();
        q1.delete();
    endtask

    always @(negedge RST_N) model_reset();

    always @(posedge CLK) begin
        if (RST_N) begin
            q0.push_back(model_step(0));
            q1.push_back(model_step(1));
        end
    end

    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("reset_h4", obs_a, RST_OBS);
            chk("reset_h1", obs_b, RST_OBS);
        end else begin
            if (q0.size() > 0) chk("hold4", obs_a, q0.pop_front());
            if (q1.size() > 0) chk("hold1", obs_b, q1.pop_front());
        end
    end

    task automatic drive(input logic [1:0] r, input int n);
        REQ = r;
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic async_reset_pulse();
        RST_N = 1'b0;
        #1;
        chk("async_rst_h4", obs_a, RST_OBS);
        chk("async_rst_h1", obs_b, RST_OBS);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0; REQ = 2'b00;
        DATA0 = '0; DATA1 = '0; BLANK0 = '0; BLANK1 = '0;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        drive(2'b00, 6);
        // single request, then drop before the hold runs out
        DATA0 = 24'h0123AF; BLANK0 = 6'b0;
        drive(2'b01, 3);
        drive(2'b00, 8);
        // reset while granted, then a tie straight out of reset
        drive(2'b01, 2);
        async_reset_pulse();
        DATA1 = 24'h5A5A5A;
        drive(2'b11, 12);
        drive(2'b00, 6);
        // one-cycle pulse; data changes during the hold must show on HEX
        DATA0 = 24'h13579B;
        drive(2'b01, 1);
        DATA0 = 24'hFEDCBA;
        drive(2'b00, 1);
        DATA0 = 24'h456789;
        drive(2'b00, 6);
        // blanking on requester 1
        DATA1 = 24'h888888; BLANK1 = 6'b101010;
        drive(2'b10, 6);
        drive(2'b00, 6);
        BLANK1 = 6'b0;
        for (int i = 0; i < 2500; i++) begin
            DATA0  = 24'($urandom);
            DATA1  = 24'($urandom);
            BLANK0 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            BLANK1 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            if ($urandom_range(0, 400) == 0) async_reset_pulse();
            drive(2'($urandom), $urandom_range(1, 6));
        end
        drive(2'b00, 8);
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
